rotate_sequencer: RTL and testbench

- Multi-cycle controller that performs an arbitrary-amount circular rotate of an N-bit operand. It reuses a small 0..7-position right-rotate stage, the same rotate behaviour as the logic unit's circular shifter, iterating it under a state machine.
- Sits beside the ALU logic unit. It serves operations whose rotate amount exceeds the 3-bit shifter range or that need a left rotate.
- Start/busy/done handshake toward the issuing control logic.

---
 rtl/rotate_sequencer_if.sv | 35 +++
 rtl/rotate_sequencer.sv | 97 +++++++++
 tb/tb_rotate_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rotate_sequencer_if.sv
// Start/busy/done request bus between the issuing control logic and the rotate sequencer.
// Optional abort line is present only when ROT_ABORT_EN is defined.
interface rotate_sequencer_if #(
    parameter int N     = 8,
    parameter int AMT_W = 8
);
    // start is taken only while busy is low (IDLE or DONE). a/amt/dir are captured
    // on that edge; done pulses for one cycle and z holds until the next completion.
    logic             start;
    logic [N-1:0]     a;
    logic [AMT_W-1:0] amt;
    logic             dir;
    logic             busy;
    logic             done;
    logic [N-1:0]     z;
`ifdef ROT_ABORT_EN
    logic             abort;
`endif

    modport master (
        output start, a, amt, dir,
`ifdef ROT_ABORT_EN
        output abort,
`endif
        input  busy, done, z
    );

    modport slave (
        input  start, a, amt, dir,
`ifdef ROT_ABORT_EN
        input  abort,
`endif
        output busy, done, z
    );
endinterface

// File: rtl/rotate_sequencer.sv
// Arbitrary-amount circular rotate built by iterating a 0..7 right-rotate stage.
// ROT_ABORT_EN adds an abort input that cancels a RUN without a done pulse.
module rotate_sequencer #(
    parameter int N     = 8,
    parameter int AMT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rotate_sequencer_if.slave    bus,
    output logic [1:0]           o_dbg_state
);
    localparam int SH_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [N-1:0]      r_acc;
    logic [SH_W-1:0]   r_rem;
    logic [N-1:0]      r_z;

    logic [SH_W-1:0]   w_eff;
    logic [SH_W-1:0]   w_r;
    logic              w_accept;
    logic              w_rem_big;
    logic              w_abort;

    function automatic logic [N-1:0] rotr(input logic [N-1:0] x, input logic [2:0] k);
        logic [2*N-1:0] w_dbl;
        w_dbl = {x, x} >> k;
        return w_dbl[N-1:0];
    endfunction

    // A left rotate by eff equals a right rotate by (N - eff) mod N.
    assign w_eff     = bus.amt[SH_W-1:0];
    assign w_r       = bus.dir ? (SH_W'(0) - w_eff) : w_eff;
    assign w_accept  = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_rem_big = (32'(r_rem) > 32'd7);

`ifdef ROT_ABORT_EN
    assign w_abort = bus.abort && (r_state == RUN);
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) w_next = RUN;
            end
            RUN: begin
                if (w_abort)         w_next = IDLE;
                else if (!w_rem_big) w_next = DONE;
            end
            DONE: begin
                w_next = bus.start ? RUN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_rem <= '0;
            r_z   <= '0;
        end else if (w_accept) begin
            r_acc <= bus.a;
            r_rem <= w_r;
        end else if ((r_state == RUN) && !w_abort) begin
            if (w_rem_big) begin
                r_acc <= rotr(r_acc, 3'd7);
                r_rem <= r_rem - SH_W'(7);
            end else begin
                r_z <= rotr(r_acc, r_rem[2:0]);
            end
        end
    end

    assign bus.busy    = (r_state == RUN);
    assign bus.done    = (r_state == DONE);
    assign bus.z       = r_z;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer at N=8 and N=32 with hand-computed results.
module tb_rotate_sequencer;
    logic clk;
    logic rst_n8;
    logic rst_n32;
    logic [1:0] dbg8;
    logic [1:0] dbg32;
    int n_checks;
    int n_pass;

    rotate_sequencer_if #(.N(8),  .AMT_W(8)) if8 ();
    rotate_sequencer_if #(.N(32), .AMT_W(8)) if32 ();

    rotate_sequencer #(.N(8), .AMT_W(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n8),
        .bus         (if8),
        .o_dbg_state (dbg8)
    );

    rotate_sequencer #(.N(32), .AMT_W(8)) u_dut32 (
        .clk         (clk),
        .rst_n       (rst_n32),
        .bus         (if32),
        .o_dbg_state (dbg32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] amt, input logic dir);
        if8.a = a; if8.amt = amt; if8.dir = dir; if8.start = 1'b1;
        step();
        if8.start = 1'b0;
    endtask

    task automatic issue32(input logic [31:0] a, input logic [7:0] amt, input logic dir);
        if32.a = a; if32.amt = amt; if32.dir = dir; if32.start = 1'b1;
        step();
        if32.start = 1'b0;
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] amt,
                        input logic dir, input logic [7:0] exp_z);
        issue8(a, amt, dir);
        check({tag, "_busy"}, 32'(if8.busy), 32'd1);
        step();
        check({tag, "_done"}, 32'(if8.done), 32'd1);
        check({tag, "_z"}, 32'(if8.z), 32'(exp_z));
        step();
        check({tag, "_done_low"}, 32'(if8.done), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n8 = 1'b0; rst_n32 = 1'b0;
        if8.start = 1'b0;  if8.a = '0;  if8.amt = '0;  if8.dir = 1'b0;
        if32.start = 1'b0; if32.a = '0; if32.amt = '0; if32.dir = 1'b0;
`ifdef ROT_ABORT_EN
        if8.abort = 1'b0; if32.abort = 1'b0;
`endif
        step(); step();
        check("rst_busy", 32'(if8.busy), 32'd0);
        check("rst_done", 32'(if8.done), 32'd0);
        check("rst_z", 32'(if8.z), 32'd0);
        check("rst_state", 32'(dbg8), 32'd0);
        check("rst_z32", if32.z, 32'd0);
        rst_n8 = 1'b1; rst_n32 = 1'b1;
        step();

        // N=8 single-step rotates
        run8("r3", 8'h96, 8'd3, 1'b0, 8'hD2);
        run8("l3", 8'h96, 8'd3, 1'b1, 8'hB4);
        run8("r11", 8'h96, 8'd11, 1'b0, 8'hD2);
        check("z_hold", 32'(if8.z), 32'hD2);

        // r=0 with a start pulsed while busy
        issue8(8'h5A, 8'd8, 1'b1);
        check("r0_busy", 32'(if8.busy), 32'd1);
        if8.a = 8'hFF; if8.amt = 8'd1; if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        check("r0_done", 32'(if8.done), 32'd1);
        check("r0_z", 32'(if8.z), 32'h5A);
        step();
        check("ign_done", 32'(if8.done), 32'd0);
        check("ign_busy", 32'(if8.busy), 32'd0);
        step();
        check("ign_done2", 32'(if8.done), 32'd0);
        check("ign_z", 32'(if8.z), 32'h5A);

        // back-to-back: start held high through DONE
        if8.a = 8'h96; if8.amt = 8'd3; if8.dir = 1'b0; if8.start = 1'b1;
        step();
        check("b2b_busy1", 32'(if8.busy), 32'd1);
        step();
        check("b2b_done1", 32'(if8.done), 32'd1);
        check("b2b_z1", 32'(if8.z), 32'hD2);
        if8.a = 8'h01; if8.amt = 8'd1; if8.dir = 1'b1;
        step();
        if8.start = 1'b0;
        check("b2b_busy2", 32'(if8.busy), 32'd1);
        check("b2b_done_mid", 32'(if8.done), 32'd0);
        step();
        check("b2b_done2", 32'(if8.done), 32'd1);
        check("b2b_z2", 32'(if8.z), 32'h02);
        step();
        check("b2b_end", 32'(if8.done), 32'd0);

        // N=32 multi-step rotate: 31 right = 5 RUN cycles
        issue32(32'h0000_0001, 8'd31, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("r31_busy%0d", i), 32'(if32.busy), 32'd1);
            check($sformatf("r31_nodone%0d", i), 32'(if32.done), 32'd0);
            step();
        end
        check("r31_done", 32'(if32.done), 32'd1);
        check("r31_z", if32.z, 32'h0000_0002);
        step();

        // z value to be preserved by abort, or cleared by reset
        issue32(32'h1234_5678, 8'd4, 1'b0);
        step();
        check("r4_z", if32.z, 32'h8123_4567);
        step();

`ifdef ROT_ABORT_EN
        issue32(32'h0000_0001, 8'd31, 1'b0);
        step(); step();
        if32.abort = 1'b1;
        step();
        if32.abort = 1'b0;
        check("abort_busy", 32'(if32.busy), 32'd0);
        check("abort_done", 32'(if32.done), 32'd0);
        check("abort_state", 32'(dbg32), 32'd0);
        check("abort_z", if32.z, 32'h8123_4567);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("abort_nodone%0d", i), 32'(if32.done), 32'd0);
            step();
        end
`endif

        // reset mid-RUN abandons the operation
        issue32(32'h0000_0001, 8'd31, 1'b0);
        step(); step();
        rst_n32 = 1'b0;
        step();
        rst_n32 = 1'b1;
        check("mrst_busy", 32'(if32.busy), 32'd0);
        check("mrst_done", 32'(if32.done), 32'd0);
        check("mrst_z", if32.z, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("mrst_nodone%0d", i), 32'(if32.done), 32'd0);
            step();
        end
        check("mrst_z_end", if32.z, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
